dpe_arbiter: RTL and testbench

- Shares one DotProductEngine between NUM_REQ requesters, such as several matrix-multiply sequencers.
- Round-robin arbitration; one job in flight at a time.
- Latches the winner as owner and muxes the owner's operand data into the DPE.
- Broadcasts DPE operand addresses to all requesters and returns the result to the owner with a one-hot response pulse.

---
 rtl/dpe_arbiter.sv | 195 +++++++++++++++++++
 tb/tb_dpe_arbiter.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dpe_arbiter.sv
// Round-robin arbiter sharing one DotProductEngine among NUM_REQ requesters, one job in flight.
// Define DPE_TIMEOUT_EN to add a RUN watchdog that returns an error response after TIMEOUT cycles.
module dpe_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int LEN_W   = 10,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 1024,
    parameter int OWN_W   = $clog2(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*LEN_W-1:0]  req_len,
    input  logic [NUM_REQ*DATA_W-1:0] req_patch_data,
    input  logic [NUM_REQ*DATA_W-1:0] req_filter_data,
    output logic [NUM_REQ-1:0]        ack,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic [DATA_W-1:0]         rsp_result,
    output logic                      rsp_err,
    output logic                      busy,
    output logic [OWN_W-1:0]          owner_id,
    output logic [9:0]                shared_patch_addr,
    output logic [9:0]                shared_filter_addr,
    output logic                      dpe_start,
    output logic [LEN_W-1:0]          dpe_vec_length,
    output logic [DATA_W-1:0]         dpe_patch_data,
    output logic [DATA_W-1:0]         dpe_filter_data,
    input  logic                      dpe_done,
    input  logic [DATA_W-1:0]         dpe_result,
    input  logic [9:0]                dpe_patch_addr,
    input  logic [9:0]                dpe_filter_addr
);

    typedef enum logic [1:0] {IDLE, RUN, ZLEN} state_t;

    if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT < 1) begin : g_bad_params
        $error("dpe_arbiter: NUM_REQ must be 2..8 and TIMEOUT at least 1");
    end

    state_t                state_reg, state_next;
    logic [OWN_W-1:0]      rr_ptr_reg, rr_ptr_next;
    logic [OWN_W-1:0]      owner_reg, owner_next;
    logic [NUM_REQ-1:0]    ack_reg, ack_next;
    logic [NUM_REQ-1:0]    rsp_valid_reg, rsp_valid_next;
    logic [DATA_W-1:0]     rsp_result_reg, rsp_result_next;
    logic                  rsp_err_reg, rsp_err_next;
    logic                  dpe_start_reg, dpe_start_next;
    logic [LEN_W-1:0]      vec_len_reg, vec_len_next;
    logic                  grant_found;
    logic [OWN_W-1:0]      grant_idx;
    logic                  timed_out;

    logic [LEN_W-1:0]  len_arr    [NUM_REQ];
    logic [DATA_W-1:0] patch_arr  [NUM_REQ];
    logic [DATA_W-1:0] filter_arr [NUM_REQ];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_slice
            assign len_arr[gi]    = req_len[gi*LEN_W +: LEN_W];
            assign patch_arr[gi]  = req_patch_data[gi*DATA_W +: DATA_W];
            assign filter_arr[gi] = req_filter_data[gi*DATA_W +: DATA_W];
        end
    endgenerate

    function automatic logic [OWN_W-1:0] wrap_add(input logic [OWN_W-1:0] base, input int off);
        int sum;
        sum = int'(base) + off;
        if (sum >= NUM_REQ) sum = sum - NUM_REQ;
        return OWN_W'(sum);
    endfunction

    // First set request at or after rr_ptr, wrapping around.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!grant_found && req[wrap_add(rr_ptr_reg, k)]) begin
                grant_found = 1'b1;
                grant_idx   = wrap_add(rr_ptr_reg, k);
            end
        end
    end

`ifdef DPE_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0] tmo_cnt_reg;

    // Zero on entry to RUN (the dpe_start cycle), then counts every RUN cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            tmo_cnt_reg <= '0;
        else if (state_reg != RUN)
            tmo_cnt_reg <= '0;
        else
            tmo_cnt_reg <= tmo_cnt_reg + 1'b1;
    end

    assign timed_out = (tmo_cnt_reg == CNT_W'(TIMEOUT));
`else
    assign timed_out = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            rr_ptr_reg     <= '0;
            owner_reg      <= '0;
            ack_reg        <= '0;
            rsp_valid_reg  <= '0;
            rsp_result_reg <= '0;
            rsp_err_reg    <= 1'b0;
            dpe_start_reg  <= 1'b0;
            vec_len_reg    <= '0;
        end else begin
            state_reg      <= state_next;
            rr_ptr_reg     <= rr_ptr_next;
            owner_reg      <= owner_next;
            ack_reg        <= ack_next;
            rsp_valid_reg  <= rsp_valid_next;
            rsp_result_reg <= rsp_result_next;
            rsp_err_reg    <= rsp_err_next;
            dpe_start_reg  <= dpe_start_next;
            vec_len_reg    <= vec_len_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        rr_ptr_next     = rr_ptr_reg;
        owner_next      = owner_reg;
        ack_next        = '0;
        rsp_valid_next  = '0;
        rsp_result_next = rsp_result_reg;
        rsp_err_next    = rsp_err_reg;
        dpe_start_next  = 1'b0;
        vec_len_next    = vec_len_reg;
        case (state_reg)
            IDLE: begin
                if (grant_found) begin
                    ack_next[grant_idx] = 1'b1;
                    owner_next          = grant_idx;
                    vec_len_next        = len_arr[grant_idx];
                    if (len_arr[grant_idx] != '0) begin
                        dpe_start_next = 1'b1;
                        state_next     = RUN;
                    end else begin
                        state_next = ZLEN;
                    end
                end
            end
            RUN: begin
                // A done coinciding with our own start pulse belongs to no job of ours.
                if (dpe_done && !dpe_start_reg) begin
                    rsp_valid_next[owner_reg] = 1'b1;
                    rsp_result_next           = dpe_result;
                    rsp_err_next              = 1'b0;
                    rr_ptr_next               = wrap_add(owner_reg, 1);
                    state_next                = IDLE;
                end else if (timed_out) begin
                    rsp_valid_next[owner_reg] = 1'b1;
                    rsp_result_next           = '0;
                    rsp_err_next              = 1'b1;
                    rr_ptr_next               = wrap_add(owner_reg, 1);
                    state_next                = IDLE;
                end
            end
            ZLEN: begin
                rsp_valid_next[owner_reg] = 1'b1;
                rsp_result_next           = '0;
                rsp_err_next              = 1'b0;
                rr_ptr_next               = wrap_add(owner_reg, 1);
                state_next                = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy            = (state_reg != IDLE);
        dpe_patch_data  = busy ? patch_arr[owner_reg]  : '0;
        dpe_filter_data = busy ? filter_arr[owner_reg] : '0;
    end

    assign ack                = ack_reg;
    assign rsp_valid          = rsp_valid_reg;
    assign rsp_result         = rsp_result_reg;
    assign rsp_err            = rsp_err_reg;
    assign owner_id           = owner_reg;
    assign dpe_start          = dpe_start_reg;
    assign dpe_vec_length     = vec_len_reg;
    assign shared_patch_addr  = dpe_patch_addr;
    assign shared_filter_addr = dpe_filter_addr;

endmodule

// File: tb/tb_dpe_arbiter.sv
// Self-checking bench for dpe_arbiter: directed scenarios plus randomized jobs checked
// against a round-robin reference model (timeout scenario only with DPE_TIMEOUT_EN).
module tb_dpe_arbiter;

    localparam int NUM_REQ    = 4;
    localparam int LEN_W      = 10;
    localparam int DATA_W     = 32;
    localparam int OWN_W      = 2;
    localparam int TB_TIMEOUT = 16;

    logic                      clk = 1'b0;
    logic                      rst_n;
    logic [NUM_REQ-1:0]        req;
    logic [LEN_W-1:0]          len_a    [NUM_REQ];
    logic [DATA_W-1:0]         patch_a  [NUM_REQ];
    logic [DATA_W-1:0]         filter_a [NUM_REQ];
    logic [NUM_REQ*LEN_W-1:0]  req_len;
    logic [NUM_REQ*DATA_W-1:0] req_patch_data;
    logic [NUM_REQ*DATA_W-1:0] req_filter_data;
    logic [NUM_REQ-1:0]        ack;
    logic [NUM_REQ-1:0]        rsp_valid;
    logic [DATA_W-1:0]         rsp_result;
    logic                      rsp_err;
    logic                      busy;
    logic [OWN_W-1:0]          owner_id;
    logic [9:0]                shared_patch_addr;
    logic [9:0]                shared_filter_addr;
    logic                      dpe_start;
    logic [LEN_W-1:0]          dpe_vec_length;
    logic [DATA_W-1:0]         dpe_patch_data;
    logic [DATA_W-1:0]         dpe_filter_data;
    logic                      dpe_done;
    logic [DATA_W-1:0]         dpe_result;
    logic [9:0]                dpe_patch_addr;
    logic [9:0]                dpe_filter_addr;

    int          n_cmp = 0;
    int          n_err = 0;
    int          mdl_ptr = 0;
    logic [31:0] last_result = '0;
    logic [3:0]  last_ack = '0;

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_pack
        assign req_len[gi*LEN_W +: LEN_W]          = len_a[gi];
        assign req_patch_data[gi*DATA_W +: DATA_W]  = patch_a[gi];
        assign req_filter_data[gi*DATA_W +: DATA_W] = filter_a[gi];
    end

    dpe_arbiter #(
        .NUM_REQ(NUM_REQ), .LEN_W(LEN_W), .DATA_W(DATA_W), .TIMEOUT(TB_TIMEOUT), .OWN_W(OWN_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .req_len(req_len),
        .req_patch_data(req_patch_data), .req_filter_data(req_filter_data),
        .ack(ack), .rsp_valid(rsp_valid), .rsp_result(rsp_result), .rsp_err(rsp_err),
        .busy(busy), .owner_id(owner_id),
        .shared_patch_addr(shared_patch_addr), .shared_filter_addr(shared_filter_addr),
        .dpe_start(dpe_start), .dpe_vec_length(dpe_vec_length),
        .dpe_patch_data(dpe_patch_data), .dpe_filter_data(dpe_filter_data),
        .dpe_done(dpe_done), .dpe_result(dpe_result),
        .dpe_patch_addr(dpe_patch_addr), .dpe_filter_addr(dpe_filter_addr)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference arbitration: first pending requester at or after the pointer, wrapping.
    function automatic int mdl_pick(input logic [3:0] mask, input int ptr);
        for (int k = 0; k < NUM_REQ; k++)
            if (mask[(ptr + k) % NUM_REQ]) return (ptr + k) % NUM_REQ;
        return -1;
    endfunction

    task automatic do_reset();
        rst_n = 1'b0;
        req = '0;
        dpe_done = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        mdl_ptr = 0;
        last_result = '0;
    endtask

    // One job: expects the arbiter idle with req pending; returns at the response cycle.
    task automatic serve(input int delay, input logic [31:0] result, input bit glitch, input bit rearm);
        int         w;
        logic [3:0] exp_bit;
        logic [9:0] exp_len;
        w = mdl_pick(req, mdl_ptr);
        if (w < 0) begin
            n_cmp++; n_err++;
            $display("FAIL serve_setup: no pending request, req=%b", req);
            return;
        end
        exp_bit = 4'b0001 << w;
        exp_len = len_a[w];
        tick();
        last_ack = ack;
        n_cmp++; if (ack !== exp_bit) begin n_err++; $display("FAIL grant_ack: got %b want %b", ack, exp_bit); end
        n_cmp++; if (owner_id !== 2'(w)) begin n_err++; $display("FAIL grant_owner: got %0d want %0d", owner_id, w); end
        n_cmp++; if (dpe_vec_length !== exp_len) begin n_err++; $display("FAIL grant_len: got %0d want %0d", dpe_vec_length, exp_len); end
        n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL grant_busy: got %b want 1", busy); end
        n_cmp++; if (dpe_start !== (exp_len != 0)) begin n_err++; $display("FAIL grant_start: got %b want %b", dpe_start, exp_len != 0); end
        n_cmp++; if (dpe_patch_data !== patch_a[w] || dpe_filter_data !== filter_a[w]) begin
            n_err++; $display("FAIL grant_mux: got %h/%h want %h/%h", dpe_patch_data, dpe_filter_data, patch_a[w], filter_a[w]);
        end
        req[w] = 1'b0;
        if (exp_len == 0) begin
            dpe_done = glitch;
            dpe_result = $urandom;
            tick();
            dpe_done = 1'b0;
            last_result = '0;
        end else begin
            dpe_done = glitch;
            dpe_result = $urandom;
            for (int d = 0; d < delay; d++) begin
                tick();
                dpe_done = 1'b0;
                n_cmp++; if (rsp_valid !== 4'b0000 || busy !== 1'b1 || dpe_start !== 1'b0) begin
                    n_err++; $display("FAIL run_wait: got rsp_valid=%b busy=%b start=%b want 0000/1/0", rsp_valid, busy, dpe_start);
                end
                n_cmp++; if (rsp_result !== last_result || dpe_patch_data !== patch_a[w]) begin
                    n_err++; $display("FAIL run_hold: got result=%h patch=%h want %h/%h", rsp_result, dpe_patch_data, last_result, patch_a[w]);
                end
            end
            dpe_done = 1'b1;
            dpe_result = result;
            tick();
            dpe_done = 1'b0;
            last_result = result;
        end
        n_cmp++; if (rsp_valid !== exp_bit || rsp_result !== last_result || rsp_err !== 1'b0) begin
            n_err++; $display("FAIL response: got v=%b r=%h e=%b want v=%b r=%h e=0", rsp_valid, rsp_result, rsp_err, exp_bit, last_result);
        end
        n_cmp++; if (busy !== 1'b0 || ack !== 4'b0000 || dpe_patch_data !== '0) begin
            n_err++; $display("FAIL resp_idle: got busy=%b ack=%b patch=%h want 0/0000/0", busy, ack, dpe_patch_data);
        end
        $display("job: owner=%0d len=%0d result=%h", w, exp_len, last_result);
        mdl_ptr = (w + 1) % NUM_REQ;
        if (rearm) req[w] = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        tick();
        n_cmp++; if (ack !== '0 || rsp_valid !== '0 || rsp_result !== '0 || rsp_err !== 1'b0) begin
            n_err++; $display("FAIL reset_rsp: got ack=%b v=%b r=%h e=%b want zeros", ack, rsp_valid, rsp_result, rsp_err);
        end
        n_cmp++; if (dpe_start !== 1'b0 || dpe_vec_length !== '0 || busy !== 1'b0 || owner_id !== '0) begin
            n_err++; $display("FAIL reset_ctl: got start=%b len=%0d busy=%b owner=%0d want zeros", dpe_start, dpe_vec_length, busy, owner_id);
        end
        n_cmp++; if (dpe_patch_data !== '0 || dpe_filter_data !== '0) begin
            n_err++; $display("FAIL reset_mux: got %h/%h want 0/0", dpe_patch_data, dpe_filter_data);
        end
        do_reset();
    endtask

    task automatic test_idle();
        req = '0;
        patch_a[0] = 32'h1234_5678;
        tick();
        tick();
        n_cmp++; if (ack !== '0 || busy !== 1'b0 || dpe_start !== 1'b0 || dpe_patch_data !== '0) begin
            n_err++; $display("FAIL idle: got ack=%b busy=%b start=%b patch=%h want zeros", ack, busy, dpe_start, dpe_patch_data);
        end
    endtask

    task automatic test_shared_addr();
        for (int i = 0; i < 4; i++) begin
            dpe_patch_addr = 10'($urandom);
            dpe_filter_addr = 10'($urandom);
            #1;
            n_cmp++; if (shared_patch_addr !== dpe_patch_addr || shared_filter_addr !== dpe_filter_addr) begin
                n_err++; $display("FAIL shared_addr: got %h/%h want %h/%h", shared_patch_addr, shared_filter_addr, dpe_patch_addr, dpe_filter_addr);
            end
        end
    endtask

    task automatic test_single_job();
        len_a[2] = 10'd3;
        patch_a[2] = 32'h3F80_0000;
        filter_a[2] = 32'h4000_0000;
        req = 4'b0100;
        serve(5, 32'h40A0_0000, 1'b0, 1'b0);
        n_cmp++; if (last_ack !== 4'b0100) begin n_err++; $display("FAIL single_ack: got %b want 0100", last_ack); end
        n_cmp++; if (rsp_result !== 32'h40A0_0000) begin n_err++; $display("FAIL single_result: got %h want 40a00000", rsp_result); end
    endtask

    task automatic test_fairness();
        do_reset();
        for (int i = 0; i < NUM_REQ; i++) len_a[i] = 10'($urandom_range(1, 3));
        req = 4'b1111;
        for (int j = 0; j < 8; j++) begin
            serve($urandom_range(1, 4), $urandom, 1'b0, 1'b1);
            n_cmp++; if (last_ack !== (4'b0001 << (j % 4))) begin
                n_err++; $display("FAIL fairness_order: job %0d got %b want %b", j, last_ack, 4'b0001 << (j % 4));
            end
        end
        req = '0;
        tick();
    endtask

    task automatic test_pointer();
        len_a[0] = 10'd2; len_a[1] = 10'd2; len_a[3] = 10'd2;
        req = 4'b0010;
        serve(2, $urandom, 1'b0, 1'b0);
        req = 4'b1001;
        serve(2, $urandom, 1'b0, 1'b0);
        n_cmp++; if (last_ack !== 4'b1000) begin n_err++; $display("FAIL pointer_first: got %b want 1000", last_ack); end
        serve(3, $urandom, 1'b0, 1'b0);
        n_cmp++; if (last_ack !== 4'b0001) begin n_err++; $display("FAIL pointer_second: got %b want 0001", last_ack); end
    endtask

    task automatic test_zero_length();
        len_a[1] = 10'd0;
        req = 4'b0010;
        serve(1, 32'h0, 1'b1, 1'b0);
        n_cmp++; if (last_ack !== 4'b0010 || rsp_valid !== 4'b0010 || rsp_result !== 32'h0) begin
            n_err++; $display("FAIL zero_len: got ack=%b v=%b r=%h want 0010/0010/0", last_ack, rsp_valid, rsp_result);
        end
    endtask

    task automatic test_reset_mid_run();
        len_a[2] = 10'd4;
        req = 4'b0100;
        tick();
        n_cmp++; if (dpe_start !== 1'b1) begin n_err++; $display("FAIL midrst_start: got %b want 1", dpe_start); end
        req = '0;
        tick(); tick(); tick();
        rst_n = 1'b0;
        #1;
        n_cmp++; if (busy !== 1'b0 || dpe_vec_length !== '0 || owner_id !== '0 || rsp_result !== '0 || dpe_patch_data !== '0) begin
            n_err++; $display("FAIL midrst_outputs: got busy=%b len=%0d owner=%0d r=%h patch=%h want zeros", busy, dpe_vec_length, owner_id, rsp_result, dpe_patch_data);
        end
        tick();
        rst_n = 1'b1;
        mdl_ptr = 0;
        last_result = '0;
        dpe_done = 1'b1;
        tick();
        dpe_done = 1'b0;
        for (int i = 0; i < 3; i++) begin
            n_cmp++; if (rsp_valid !== '0 || busy !== 1'b0) begin
                n_err++; $display("FAIL midrst_stale_done: got v=%b busy=%b want 0000/0", rsp_valid, busy);
            end
            tick();
        end
        len_a[0] = 10'd1; len_a[3] = 10'd1;
        req = 4'b1001;
        serve(1, $urandom, 1'b0, 1'b0);
        n_cmp++; if (last_ack !== 4'b0001) begin n_err++; $display("FAIL midrst_ptr: got %b want 0001", last_ack); end
        req = '0;
        tick();
    endtask

    task automatic test_random();
        for (int j = 0; j < 25; j++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                len_a[i]    = ($urandom_range(0, 3) == 0) ? 10'd0 : 10'($urandom_range(1, 20));
                patch_a[i]  = $urandom;
                filter_a[i] = $urandom;
            end
            req = req | 4'($urandom);
            if (req == '0) req[$urandom_range(0, 3)] = 1'b1;
            serve($urandom_range(1, 6), $urandom, 1'($urandom_range(0, 1)), 1'b0);
        end
        req = '0;
        tick();
    endtask

`ifdef DPE_TIMEOUT_EN
    task automatic test_timeout();
        len_a[1] = 10'd5;
        req = 4'b0010;
        mdl_ptr = mdl_pick(req, mdl_ptr);
        tick();
        n_cmp++; if (dpe_start !== 1'b1 || ack !== 4'b0010) begin
            n_err++; $display("FAIL tmo_grant: got start=%b ack=%b want 1/0010", dpe_start, ack);
        end
        req = '0;
        for (int i = 1; i <= TB_TIMEOUT; i++) begin
            tick();
            n_cmp++; if (rsp_valid !== '0) begin n_err++; $display("FAIL tmo_early: cycle %0d got v=%b want 0000", i, rsp_valid); end
        end
        tick();
        n_cmp++; if (rsp_valid !== 4'b0010 || rsp_err !== 1'b1 || rsp_result !== '0 || busy !== 1'b0) begin
            n_err++; $display("FAIL tmo_rsp: got v=%b e=%b r=%h busy=%b want 0010/1/0/0", rsp_valid, rsp_err, rsp_result, busy);
        end
        mdl_ptr = 2;
        last_result = '0;
        dpe_done = 1'b1;
        tick();
        dpe_done = 1'b0;
        n_cmp++; if (rsp_valid !== '0) begin n_err++; $display("FAIL tmo_late_done: got v=%b want 0000", rsp_valid); end
        len_a[0] = 10'd2;
        req = 4'b0001;
        serve(2, $urandom, 1'b0, 1'b0);
    endtask
`endif

    initial begin
        rst_n = 1'b0;
        req = '0;
        dpe_done = 1'b0;
        dpe_result = '0;
        dpe_patch_addr = '0;
        dpe_filter_addr = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            len_a[i] = '0; patch_a[i] = '0; filter_a[i] = '0;
        end
        test_reset();
        test_idle();
        test_shared_addr();
        test_single_job();
        test_fairness();
        test_pointer();
        test_zero_length();
        test_reset_mid_run();
        test_random();
`ifdef DPE_TIMEOUT_EN
        test_timeout();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
